// File: rtl/ahb_pkg.sv
// Shared definitions for the AHB memory responder: FSM states, response
// codes and bus word geometry.
package ahb_pkg;

    // Responder transfer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ahb_slave_regfile.sv
// DEPTH x 32 word store with one write port and one registered read port.
// A read that targets the word being written on the same edge returns the
// incoming write data, so a back-to-back read never sees stale contents.
module ahb_slave_regfile #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      r_rdata;
    logic [DEPTH-1:0] w_word_we;
    logic             w_fwd;

    // Per-word write strobes decoded from the write index.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign w_word_we[gi] = i_we && (i_waddr == IDX_W'(gi));
        end
    endgenerate

    assign w_fwd = i_we && (i_waddr == i_raddr);

    // Word storage: cleared by reset, one word written per cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_word_we[i]) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Registered read data; only changes when a read is launched.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_fwd ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-style memory responder: self-selects from the one-hot sel bus, decodes
// the word address, inserts configurable wait states and answers bad
// addresses with a two-cycle ERROR response.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int          SLAVE_IDX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [3:0]  sel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH * WORD_BYTES);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_wait_cnt;
    logic [2:0]       w_wait_cnt_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_write;

    logic             w_sel_me;
    logic             w_ready;
    logic             w_resp;
    logic             w_accept;
    logic             w_err;
    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic             w_we;
    logic             w_re;
    logic [IDX_W-1:0] w_raddr;

    // Address decode: the offset compare is unsigned, so addresses below the
    // base wrap to huge offsets, but they are also rejected explicitly.
    assign w_sel_me = |(sel & (4'b0001 << SLAVE_IDX));
    assign w_offset = haddr - BASE_ADDR;
    assign w_err    = (haddr[1:0] != 2'b00) || (haddr < BASE_ADDR) || (w_offset >= SPAN);
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_accept = w_sel_me && hready && w_ready;

    // Output decode from the current state only, keeping accept loop-free.
    always_comb begin
        w_ready = 1'b1;
        w_resp  = HRESP_OKAY;
        case (r_state)
            ST_WAIT: w_ready = 1'b0;
            ST_ERR1: begin
                w_ready = 1'b0;
                w_resp  = HRESP_ERROR;
            end
            ST_ERR2: w_resp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Next-state: IDLE, DATA and ERR2 all share the same accept rule.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_next    = ST_WAIT;
                        w_wait_cnt_next = WAIT_INIT;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_wait_cnt_next = r_wait_cnt - 3'd1;
                if (r_wait_cnt <= 3'd1) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_ERR1: w_state_next = ST_ERR2;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, wait counter and latched transfer attributes.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_write    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_write <= hwrite;
            end
        end
    end

    // A write commits at the edge closing its DATA cycle. A read launches on
    // the edge entering DATA: straight from the accept when there are no
    // wait states, otherwise from the last WAIT cycle using the latched index.
    assign w_we    = (r_state == ST_DATA) && r_write;
    assign w_re    = (w_accept && !w_err && !hwrite && (WAIT_STATES == 0)) ||
                     ((r_state == ST_WAIT) && (r_wait_cnt == 3'd1) && !r_write);
    assign w_raddr = (r_state == ST_WAIT) ? r_idx : w_idx;

    ahb_slave_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .hclk    (hclk),
        .hresetn (hresetn),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (hwdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (hrdata)
    );

    assign hreadyout = w_ready;
    assign hresp     = w_resp;

endmodule
